// File: rtl/cpu_lite_pkg.sv
// Shared definitions for the program-memory load/issue path.
package cpu_lite_pkg;

  localparam int         ADD_WIDTH   = 4;
  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pm_seq_state_t;

endpackage

// File: rtl/pm_ram.sv
// Program memory: one synchronous write port and one registered read port.
module pm_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          re_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // The array itself keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the output register is cleared, so a reset blanks the issued instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (re_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pm_load_sequencer.sv
// Captures a program over the load port, then issues it in address order to the
// core over a valid/ready handshake until the last address or a halt opcode.
module pm_load_sequencer #(
  parameter int                    ADD_WIDTH   = cpu_lite_pkg::ADD_WIDTH,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = DATA_WIDTH'(cpu_lite_pkg::HALT_OPCODE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmWrEn,
  input  logic [ADD_WIDTH-1:0]  pm_addr,
  input  logic [DATA_WIDTH-1:0] instructionIn,
  input  logic                  start,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADD_WIDTH-1:0]  instr_addr,
  output logic                  instr_valid,
  output logic [ADD_WIDTH:0]    prog_len,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);

  localparam int LW = ADD_WIDTH + 1;

  cpu_lite_pkg::pm_seq_state_t state_q;

  logic [LW-1:0]         pc_q;
  logic [LW-1:0]         prog_len_q;
  logic [LW-1:0]         prog_len_d;
  logic [LW-1:0]         wr_len;
  logic [ADD_WIDTH-1:0]  instr_addr_q;
  logic                  instr_valid_q;
  logic                  wr_err_q;
  logic                  wr_en;
  logic                  beat;
  logic                  run_end;
  logic                  refill;
  logic [DATA_WIDTH-1:0] rd_data;

  // Writes land in memory in LOAD and DONE; a write during RUN only flags an error.
  assign wr_en      = pmWrEn && (state_q != cpu_lite_pkg::RUN);
  assign wr_len     = {1'b0, pm_addr} + LW'(1);
  assign prog_len_d = (wr_en && (wr_len > prog_len_q)) ? wr_len : prog_len_q;

  assign beat    = (state_q == cpu_lite_pkg::RUN) && instr_valid_q && instr_ready;
  assign run_end = beat && (({1'b0, instr_addr_q} == (prog_len_q - LW'(1))) ||
                            (rd_data == HALT_OPCODE));
  // pc is one bit wider than the address, so it stops at prog_len instead of wrapping.
  assign refill  = (state_q == cpu_lite_pkg::RUN) && (!instr_valid_q || instr_ready) &&
                   (pc_q < prog_len_q) && !run_end;

  pm_ram #(
    .AW (ADD_WIDTH),
    .DW (DATA_WIDTH)
  ) u_pm_ram (
    .clk_i     (clk),
    .rst_ni    (rst),
    .we_i      (wr_en),
    .wr_addr_i (pm_addr),
    .wr_data_i (instructionIn),
    .re_i      (refill),
    .rd_addr_i (pc_q[ADD_WIDTH-1:0]),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= cpu_lite_pkg::LOAD;
      pc_q          <= '0;
      prog_len_q    <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      prog_len_q <= prog_len_d;
      case (state_q)
        cpu_lite_pkg::LOAD: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= (prog_len_d == '0) ? cpu_lite_pkg::DONE : cpu_lite_pkg::RUN;
          end
        end
        cpu_lite_pkg::RUN: begin
          if (pmWrEn) begin
            wr_err_q <= 1'b1;
          end
          if (run_end) begin
            state_q       <= cpu_lite_pkg::DONE;
            instr_valid_q <= 1'b0;
          end else if (refill) begin
            instr_addr_q  <= pc_q[ADD_WIDTH-1:0];
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + LW'(1);
          end else if (beat) begin
            instr_valid_q <= 1'b0;
          end
        end
        cpu_lite_pkg::DONE: begin
          if (start) begin
            pc_q     <= '0;
            wr_err_q <= 1'b0;
            state_q  <= (prog_len_d == '0) ? cpu_lite_pkg::DONE : cpu_lite_pkg::RUN;
          end else if (pmWrEn) begin
            state_q <= cpu_lite_pkg::LOAD;
          end
        end
        default: begin
          state_q       <= cpu_lite_pkg::LOAD;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_out   = rd_data;
  assign instr_addr  = instr_addr_q;
  assign instr_valid = instr_valid_q;
  assign prog_len    = prog_len_q;
  assign busy        = (state_q == cpu_lite_pkg::RUN);
  assign done        = (state_q == cpu_lite_pkg::DONE);
  assign wr_err      = wr_err_q;

endmodule
